wb_commit: RTL and testbench
============================

// Module: wb_commit
// PURPOSE
//  Write-side master of the RV32I register file: collects results from the ALU
//  (single-cycle) and the LSU (multi-cycle loads) over valid/ready, arbitrates,
//  and drives the regfile write port (reg_wr_en/rd_addr/w_data) from registers.
//  Also holds a per-register pending-write scoreboard that decode uses to stall
//  RAW/WAW hazards. Sits between execute/LSU and the regfile.
// PARAMETERS
//  XLEN          32  data width of results and w_data
//  NREGS         32  architectural registers; x0 hardwired zero
//  AW             5  register address width, equals $clog2(NREGS)
//  LSU_PRIORITY   1  1: LSU wins a simultaneous request; 0: ALU wins
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      asynchronous reset, active-low (asserted when 0)
//  alu_valid  in   1      ALU result available
//  alu_rd     in   AW     ALU destination register
//  alu_data   in   XLEN   ALU result
//  alu_ready  out  1      ALU result accepted this cycle (combinational)
//  lsu_valid  in   1      load result available
//  lsu_rd     in   AW     load destination register
//  lsu_data   in   XLEN   load result
//  lsu_ready  out  1      load result accepted this cycle (combinational)
//  issue_en   in   1      decode issues an instruction writing issue_rd
//  issue_rd   in   AW     destination of the issuing instruction
//  rs1_addr   in   AW     source 1 of the instruction in decode
//  rs2_addr   in   AW     source 2 of the instruction in decode
//  stall      out  1      decode must not issue (combinational)
//  busy       out  NREGS  scoreboard, bit i = write to xi pending
//  reg_wr_en  out  1      regfile write enable (registered)
//  rd_addr    out  AW     regfile write address (registered)
//  w_data     out  XLEN   regfile write data (registered)
// BEHAVIOUR
//  - Reset (rst=0, async): reg_wr_en=0, rd_addr=0, w_data=0, busy=0; while rst=0
//    alu_ready=lsu_ready=0 and stall=1.
//  - Arbitration, one commit per cycle: if only one source valid, its ready=1.
//    Both valid: LSU_PRIORITY picks the winner (ready=1), loser ready=0 and must
//    hold valid/rd/data stable until accepted. Neither valid: both ready=0.
//  - Accepted result (valid&ready at edge) loads rd_addr/w_data next edge with
//    reg_wr_en=1: latency 1 cycle; regfile writes on the following edge.
//  - No accept: reg_wr_en=0 next cycle; rd_addr/w_data hold last value.
//  - rd=0 result: handshake completes (ready=1) but reg_wr_en stays 0, busy
//    unchanged; x0 is never written.
//  - Scoreboard: busy[issue_rd] set on edge where issue_en=1, stall=0,
//    issue_rd!=0. busy[rd_addr] cleared on edge where reg_wr_en=1.
//    Same register set and cleared on one edge: set wins (result = 1).
//    busy[0] always 0.
//  - stall = busy[rs1_addr] | busy[rs2_addr] | (busy[issue_rd] & issue_en)
//    (WAW stall); address 0 never stalls. issue_en while stall=1 is ignored.
//  - Result whose rd has busy=0 (protocol error): still committed, busy stays 0.
//  - Reset mid-operation: in-flight commit dropped (reg_wr_en forced 0
//    immediately), all busy bits cleared; upstream resends after reset.
// TESTING
//  1 Reset: rst=0 two cycles -> reg_wr_en=0, busy=0, stall=1, readies=0.
//  2 ALU only: issue x1; alu_valid, rd=1, data=32'hAAAAAAAA -> alu_ready=1;
//    next cycle reg_wr_en=1, rd_addr=1, w_data=AAAAAAAA; busy[1] 1->0 after.
//  3 Conflict: ALU x5=DEADBEEF and LSU x10=C0FFEE00 same cycle, LSU_PRIORITY=1
//    -> x10 commits first, ALU held one cycle, x5 commits next; no loss.
//  4 x0: ALU rd=0 data=FFFFFFFF -> alu_ready=1, reg_wr_en stays 0, busy=0.
//  5 Hazard: issue x7, then rs1_addr=7 -> stall=1 until commit edge of x7,
//    stall=0 the cycle after; issue_rd=7 again while busy -> ignored.
//  6 Reset mid-commit: rst=0 while reg_wr_en=1 -> reg_wr_en=0, busy=0 at once.

Source files
------------

// File: rtl/wb_commit.sv
// Write-back commit stage: arbitrates ALU/LSU results onto the regfile write
// port and keeps the pending-write scoreboard used by decode for hazard stalls.
module wb_commit #(
  parameter int XLEN         = 32,
  parameter int NREGS        = 32,
  parameter int AW           = 5,
  parameter bit LSU_PRIORITY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             lsu_valid,
  input  logic [AW-1:0]    lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  output logic             lsu_ready,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic             stall,
  output logic [NREGS-1:0] busy,
  output logic             reg_wr_en,
  output logic [AW-1:0]    rd_addr,
  output logic [XLEN-1:0]  w_data
);

  logic             reg_wr_en_reg;
  logic [AW-1:0]    rd_addr_reg;
  logic [XLEN-1:0]  w_data_reg;
  logic [NREGS-1:1] busy_reg;
  logic [NREGS-1:1] set_vec;
  logic [NREGS-1:1] clr_vec;

  logic             lsu_wins;
  logic             accept;
  logic [AW-1:0]    sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic             commit_next;
  logic             issue_ok;

  // Readies stay low while reset is held so nothing is consumed and lost.
  assign lsu_wins  = lsu_valid && (!alu_valid || LSU_PRIORITY);
  assign lsu_ready = rst && lsu_wins;
  assign alu_ready = rst && alu_valid && !lsu_wins;
  assign accept    = alu_ready || lsu_ready;

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (lsu_wins) begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end
  end

  // x0 results complete the handshake but never reach the regfile.
  assign commit_next = accept && (sel_rd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_wr_en_reg <= 1'b0;
      rd_addr_reg   <= '0;
      w_data_reg    <= '0;
    end else begin
      reg_wr_en_reg <= commit_next;
      if (commit_next) begin
        rd_addr_reg <= sel_rd;
        w_data_reg  <= sel_data;
      end
    end
  end

  assign busy     = {busy_reg, 1'b0};
  assign stall    = !rst || busy[rs1_addr] || busy[rs2_addr] || (busy[issue_rd] && issue_en);
  assign issue_ok = issue_en && !stall;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_busy
      assign set_vec[gi] = issue_ok && (issue_rd == AW'(gi));
      assign clr_vec[gi] = reg_wr_en_reg && (rd_addr_reg == AW'(gi));
      // A new issue to the register being retired this edge keeps it pending.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          busy_reg[gi] <= 1'b0;
        else if (set_vec[gi])
          busy_reg[gi] <= 1'b1;
        else if (clr_vec[gi])
          busy_reg[gi] <= 1'b0;
      end
    end
  endgenerate

  assign reg_wr_en = reg_wr_en_reg;
  assign rd_addr   = rd_addr_reg;
  assign w_data    = w_data_reg;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: stimulus pushes expected commits into a queue,
// a negedge monitor pops and compares every regfile write the DUT presents.
module tb_wb_commit;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid, lsu_valid, issue_en;
  logic [AW-1:0]    alu_rd, lsu_rd, issue_rd, rs1_addr, rs2_addr;
  logic [XLEN-1:0]  alu_data, lsu_data;
  logic             alu_ready, lsu_ready, stall, reg_wr_en;
  logic [NREGS-1:0] busy;
  logic [AW-1:0]    rd_addr;
  logic [XLEN-1:0]  w_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW+XLEN-1:0] exp_q[$];

  wb_commit #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .LSU_PRIORITY(1'b1)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_en(issue_en), .issue_rd(issue_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .stall(stall), .busy(busy),
    .reg_wr_en(reg_wr_en), .rd_addr(rd_addr), .w_data(w_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write the DUT presents must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst === 1'b1 && reg_wr_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL commit_unexpected: got x%0d=%h expected no write", rd_addr, w_data);
      end else begin
        logic [AW+XLEN-1:0] e;
        e = exp_q.pop_front();
        if ({rd_addr, w_data} !== e) begin
          n_err++;
          $display("FAIL commit: got x%0d=%h expected x%0d=%h",
                   rd_addr, w_data, e[AW+XLEN-1:XLEN], e[XLEN-1:0]);
        end else begin
          $display("commit x%0d=%h", rd_addr, w_data);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = '0;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = '0;
    issue_en = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;

    // 1: reset held two cycles, requests pending but not consumed
    repeat (2) step();
    chk("rst_wr_en", reg_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 1);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_rd_wdata", {rd_addr, w_data}, 0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("post_rst_stall", stall, 0);

    // 2: ALU-only commit of x1
    issue_en = 1'b1; issue_rd = 5'd1;
    step();
    issue_en = 1'b0;
    chk("t2_busy_set", busy, 32'h0000_0002);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hAAAAAAAA;
    exp_q.push_back({5'd1, 32'hAAAAAAAA});
    #1;
    chk("t2_alu_ready", alu_ready, 1);
    chk("t2_lsu_ready", lsu_ready, 0);
    step();
    alu_valid = 1'b0;
    chk("t2_wr_en", reg_wr_en, 1);
    chk("t2_busy_held", busy, 32'h0000_0002);
    step();
    chk("t2_busy_clr", busy, 0);
    chk("t2_wr_en_off", reg_wr_en, 0);
    chk("t2_hold_wdata", w_data, 32'hAAAAAAAA);

    // 3: simultaneous ALU x5 and LSU x10, LSU has priority
    issue_en = 1'b1; issue_rd = 5'd5;
    step();
    issue_rd = 5'd10;
    step();
    issue_en = 1'b0;
    chk("t3_busy", busy, 32'h0000_0420);
    alu_valid = 1'b1; alu_rd = 5'd5;  alu_data = 32'hDEADBEEF;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hC0FFEE00;
    exp_q.push_back({5'd10, 32'hC0FFEE00});
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    #1;
    chk("t3_lsu_ready", lsu_ready, 1);
    chk("t3_alu_ready_held", alu_ready, 0);
    step();
    lsu_valid = 1'b0;
    #1;
    chk("t3_alu_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    step();
    chk("t3_busy_clr", busy, 0);

    // 4: x0 result is accepted but never written
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    #1;
    chk("t4_alu_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    chk("t4_wr_en", reg_wr_en, 0);
    chk("t4_busy", busy, 0);

    // 5: RAW hazard on x7; issues while stalled are dropped
    issue_en = 1'b1; issue_rd = 5'd7;
    step();
    issue_en = 1'b0;
    rs1_addr = 5'd7;
    #1;
    chk("t5_raw_stall", stall, 1);
    issue_en = 1'b1; issue_rd = 5'd9;
    step();
    issue_en = 1'b0;
    chk("t5_ignored_issue", busy, 32'h0000_0080);
    rs1_addr = 5'd0; issue_en = 1'b1; issue_rd = 5'd7;
    #1;
    chk("t5_waw_stall", stall, 1);
    step();
    issue_en = 1'b0; rs1_addr = 5'd7;
    chk("t5_waw_ignored", busy, 32'h0000_0080);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h12345678;
    exp_q.push_back({5'd7, 32'h12345678});
    step();
    alu_valid = 1'b0;
    chk("t5_stall_commit_cycle", stall, 1);
    step();
    chk("t5_stall_released", stall, 0);
    chk("t5_busy_clr", busy, 0);
    rs1_addr = 5'd0;

    // 6: reset asserted while a write is on the port
    issue_en = 1'b1; issue_rd = 5'd3;
    step();
    issue_en = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h55555555;
    step();
    alu_valid = 1'b0;
    chk("t6_wr_en_before", reg_wr_en, 1);
    rst = 1'b0;
    #1;
    chk("t6_wr_en_dropped", reg_wr_en, 0);
    chk("t6_busy_cleared", busy, 0);
    chk("t6_stall", stall, 1);
    step();
    rst = 1'b1;
    repeat (3) step();

    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    $fatal(1);
  end

endmodule
